// File: rtl/exe_stage.sv
// Execute stage of the 8-bit 5-stage pipeline. It forwards operands, runs the ALU, holds the C/Z flags,
// resolves conditional branches, and contains the EXE/MEM pipeline register.
module exe_stage #(
  parameter int DW = 8,
  parameter int AW = 12,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          regWr_IN,
  input  logic          memRd_IN,
  input  logic          memWr_IN,
  input  logic          cWr_IN,
  input  logic          zWr_IN,
  input  logic [3:0]    aluOp_IN,
  input  logic [4:0]    opCode_IN,
  input  logic [RW-1:0] rd_IN,
  input  logic [RW-1:0] rs_IN,
  input  logic [RW-1:0] rt_IN,
  input  logic [DW-1:0] regData1_IN,
  input  logic [DW-1:0] regData2_IN,
  input  logic [DW-1:0] immConst_IN,
  input  logic [DW-1:0] brDisp_IN,
  input  logic [AW-1:0] pcPlus1_IN,
  input  logic          memFwdWr_IN,
  input  logic [RW-1:0] memFwdRd_IN,
  input  logic [DW-1:0] memFwdData_IN,
  input  logic          wbFwdWr_IN,
  input  logic [RW-1:0] wbFwdRd_IN,
  input  logic [DW-1:0] wbFwdData_IN,
  output logic          regWr_OUT,
  output logic          memRd_OUT,
  output logic          memWr_OUT,
  output logic [RW-1:0] rd_OUT,
  output logic [DW-1:0] aluResult_OUT,
  output logic [DW-1:0] storeData_OUT,
  output logic          cFlag_OUT,
  output logic          zFlag_OUT,
  output logic          brTaken_OUT,
  output logic [AW-1:0] brTarget_OUT,
  output logic          flush_OUT
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_ADC  = 4'd1,  OP_SUB = 4'd2,  OP_SBC = 4'd3,
    OP_AND  = 4'd4,  OP_OR   = 4'd5,  OP_XOR = 4'd6,  OP_MASK = 4'd7,
    OP_SHL  = 4'd8,  OP_SHR  = 4'd9,  OP_ROL = 4'd10, OP_ROR = 4'd11,
    OP_PASSB = 4'd12, OP_R13 = 4'd13, OP_R14 = 4'd14, OP_R15 = 4'd15
  } alu_op_e;

  logic          cFlag_q, cFlag_d;
  logic          zFlag_q, zFlag_d;
  logic          regWr_q, memRd_q, memWr_q;
  logic [RW-1:0] rd_q;
  logic [DW-1:0] aluRes_q, store_q;

  logic [DW-1:0] opA, rtVal, opB;
  logic [DW-1:0] res;
  logic          cNew;
  logic [DW:0]   sum;
  alu_op_e       op;

  // MEM beats WB; register 0 is an ordinary forwardable address.
  always_comb begin
    opA = regData1_IN;
    if (memFwdWr_IN && (memFwdRd_IN == rs_IN))    opA = memFwdData_IN;
    else if (wbFwdWr_IN && (wbFwdRd_IN == rs_IN)) opA = wbFwdData_IN;

    rtVal = regData2_IN;
    if (memFwdWr_IN && (memFwdRd_IN == rt_IN))    rtVal = memFwdData_IN;
    else if (wbFwdWr_IN && (wbFwdRd_IN == rt_IN)) rtVal = wbFwdData_IN;
  end

  assign opB = (opCode_IN[4:3] == 2'b10) ? immConst_IN : rtVal;
  assign op  = alu_op_e'(aluOp_IN);

  always_comb begin
    res  = opA;
    cNew = cFlag_q;
    sum  = '0;
    case (op)
      OP_ADD: begin
        sum  = {1'b0, opA} + {1'b0, opB};
        res  = sum[DW-1:0];
        cNew = sum[DW];
      end
      OP_ADC: begin
        sum  = {1'b0, opA} + {1'b0, opB} + {{DW{1'b0}}, cFlag_q};
        res  = sum[DW-1:0];
        cNew = sum[DW];
      end
      // Subtract by adding the complement: carry-out 1 means no borrow.
      OP_SUB: begin
        sum  = {1'b0, opA} + {1'b0, ~opB} + {{DW{1'b0}}, 1'b1};
        res  = sum[DW-1:0];
        cNew = sum[DW];
      end
      OP_SBC: begin
        sum  = {1'b0, opA} + {1'b0, ~opB} + {{DW{1'b0}}, cFlag_q};
        res  = sum[DW-1:0];
        cNew = sum[DW];
      end
      OP_AND:   res = opA & opB;
      OP_OR:    res = opA | opB;
      OP_XOR:   res = opA ^ opB;
      OP_MASK:  res = opA & ~opB;
      OP_SHL: begin
        res  = {opA[DW-2:0], 1'b0};
        cNew = opA[DW-1];
      end
      OP_SHR: begin
        res  = {1'b0, opA[DW-1:1]};
        cNew = opA[0];
      end
      OP_ROL: begin
        res  = {opA[DW-2:0], opA[DW-1]};
        cNew = opA[DW-1];
      end
      OP_ROR: begin
        res  = {opA[0], opA[DW-1:1]};
        cNew = opA[0];
      end
      OP_PASSB: res = opB;
      default:  res = opA;
    endcase
  end

  assign cFlag_d = cWr_IN ? cNew : cFlag_q;
  assign zFlag_d = zWr_IN ? (res == '0) : zFlag_q;

  // Branches test the flags as they stand before this edge's write.
  always_comb begin
    brTaken_OUT = 1'b0;
    if (opCode_IN[4:2] == 3'b111) begin
      case (opCode_IN[1:0])
        2'b00:   brTaken_OUT = zFlag_q;
        2'b01:   brTaken_OUT = ~zFlag_q;
        2'b10:   brTaken_OUT = cFlag_q;
        default: brTaken_OUT = ~cFlag_q;
      endcase
    end
  end

  assign brTarget_OUT = pcPlus1_IN + {{(AW-DW){brDisp_IN[DW-1]}}, brDisp_IN};
  assign flush_OUT    = brTaken_OUT;

  always_ff @(posedge clk) begin
    if (rst) begin
      cFlag_q  <= 1'b0;
      zFlag_q  <= 1'b0;
      regWr_q  <= 1'b0;
      memRd_q  <= 1'b0;
      memWr_q  <= 1'b0;
      rd_q     <= '0;
      aluRes_q <= '0;
      store_q  <= '0;
    end else begin
      cFlag_q  <= cFlag_d;
      zFlag_q  <= zFlag_d;
      regWr_q  <= regWr_IN;
      memRd_q  <= memRd_IN;
      memWr_q  <= memWr_IN;
      rd_q     <= rd_IN;
      aluRes_q <= res;
      store_q  <= rtVal;
    end
  end

  assign regWr_OUT     = regWr_q;
  assign memRd_OUT     = memRd_q;
  assign memWr_OUT     = memWr_q;
  assign rd_OUT        = rd_q;
  assign aluResult_OUT = aluRes_q;
  assign storeData_OUT = store_q;
  assign cFlag_OUT     = cFlag_q;
  assign zFlag_OUT     = zFlag_q;

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 8-bit, 5-stage pipeline. Sits directly downstream of the ID/EXE pipeline register and consumes its outputs.
- Resolves operand forwarding from MEM and WB, performs the ALU operation, and holds the architectural carry (C) and zero (Z) flags.
- Resolves conditional branches and produces the branch target and flush request.
- Contains the EXE/MEM pipeline register that feeds the memory stage.

Parameters:
- DW, 8, datapath width
- AW, 12, PC width
- RW, 3, register-address width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- regWr_IN, memRd_IN, memWr_IN, cWr_IN, zWr_IN  in  1 each  control fields from ID/EXE
- aluOp_IN  in  4  ALU operation
- opCode_IN  in  5  instruction opcode
- rd_IN, rs_IN, rt_IN  in  RW each  destination and source register addresses
- regData1_IN, regData2_IN, immConst_IN, brDisp_IN  in  DW each  register-file read data, immediate, branch displacement
- pcPlus1_IN  in  AW  PC+1 of the instruction in EXE
- memFwdWr_IN  in  1  MEM-stage instruction writes a register
- memFwdRd_IN  in  RW  MEM-stage destination
- memFwdData_IN  in  DW  MEM-stage ALU result
- wbFwdWr_IN  in  1  WB-stage instruction writes a register
- wbFwdRd_IN  in  RW  WB-stage destination
- wbFwdData_IN  in  DW  WB-stage write data
- regWr_OUT, memRd_OUT, memWr_OUT  out  1 each  registered to MEM
- rd_OUT  out  RW  registered to MEM
- aluResult_OUT  out  DW  registered ALU result / memory address
- storeData_OUT  out  DW  registered forwarded rt value
- cFlag_OUT, zFlag_OUT  out  1 each  current flag registers
- brTaken_OUT  out  1  combinational: branch in EXE is taken
- brTarget_OUT  out  AW  combinational branch target
- flush_OUT  out  1  combinational, equals brTaken_OUT; upstream squashes IF/ID and ID/EXE

Behaviour:
- Reset: on a rising clk edge with rst=1, all registered outputs and both flags go to 0. rst is synchronous only, so an in-flight instruction is discarded and the EXE/MEM register shows a bubble (all 0) the next cycle.
- Forwarding, separately for operand A (rs, regData1) and rt:
  - If memFwdWr_IN and memFwdRd_IN==addr, use memFwdData_IN.
  - Else if wbFwdWr_IN and wbFwdRd_IN==addr, use wbFwdData_IN.
  - Else use the register-file data.
  - MEM has priority over WB. All addresses, including 0, are forwardable.
  - Load-use hazards are stalled upstream; this block does not stall.
- Operand B: immConst_IN when opCode_IN[4:3]==2'b10 (immediate ALU class), else the forwarded rt value.
- ALU, 8-bit, results wrap modulo 256. cin is the current C flag. "C updated" below means the value written to C when cWr_IN=1.
  - 0 ADD: A+B; C = carry-out.
  - 1 ADC: A+B+cin; C = carry-out.
  - 2 SUB: A+~B+1; C = carry-out (1 = no borrow).
  - 3 SBC: A+~B+cin; C = carry-out.
  - 4 AND, 5 OR, 6 XOR: bitwise; C unchanged.
  - 7 MASK: A & ~B; C unchanged.
  - 8 SHL: A<<1; C = A[7].
  - 9 SHR: A>>1 logical; C = A[0].
  - 10 ROL: {A[6:0],A[7]}; C = A[7].
  - 11 ROR: {A[0],A[7:1]}; C = A[0].
  - 12 PASS_B: result = B; C unchanged.
  - 13-15: result = A; C unchanged.
- Flags:
  - On each edge, C is loaded only when cWr_IN=1, and Z (result==0) only when zWr_IN=1.
  - Flags written by instruction N are visible to instruction N+1 in the next cycle, so no flag hazard exists.
  - If a branch and a flag write coincide, the branch uses the pre-edge flag values.
- Branch:
  - opCode_IN 11100 BZ (Z=1), 11101 BNZ (Z=0), 11110 BC (C=1), 11111 BNC (C=0).
  - brTaken_OUT is asserted when the condition holds; it is 0 for all other opcodes.
  - brTarget_OUT = pcPlus1_IN + sign-extended brDisp_IN, modulo 2^12 (wraps at 0xFFF to 0x000). It is computed every cycle regardless of opcode.
  - A branch still propagates its regWr/memRd/memWr (normally 0) to EXE/MEM.
- EXE/MEM register: latency 1 cycle. Every non-reset edge loads regWr, memRd, memWr, rd, ALU result and forwarded rt, with no enable. Bubbles arrive as all-zero control from ID/EXE.

Test Plan:
- rst=1 for one edge while valid ADD is presented -> next cycle all registered outputs 0, cFlag_OUT=0, zFlag_OUT=0.
- ADD with A=0xF0, B=0x20, cWr=zWr=1 -> aluResult_OUT=0x10, C=1, Z=0. Then ADC 0x01+0x01 -> 0x03.
- SUB with R1=5; MEM forwards R1=9 while WB forwards R1=7 -> MEM wins, A=9; with B=9 result 0x00, Z=1, C=1.
- BZ with Z=1, pcPlus1=0x005, brDisp=0xFB (-5) -> brTaken_OUT=1, flush_OUT=1, brTarget_OUT=0x000. Same with pcPlus1=0xFFF, brDisp=0x02 -> 0x001.
- ROR A=0x01 with cWr=1 -> result 0x80, C=1. Next cycle BNC -> not taken; BC -> taken.
- Immediate class (opCode 10xxx) AND with rt forwarded from WB -> B uses immConst_IN, while storeData_OUT still carries the forwarded rt value.
